// File: rtl/ro_puf_counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ro_puf_counter_ctrl_pkg
// Purpose  : Shared state encoding and default sizing for the RO PUF counter.
// Revision : 1.0 - initial release
// ============================================================================
package ro_puf_counter_ctrl_pkg;

    // ST_DONE is also the completion code the PUF controller polls for.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_COUNT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_WINDOW = 1024;
    localparam int DEF_WIN_W  = 11;

endpackage
`default_nettype wire

// File: rtl/ro_puf_counter_ctrl_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : ro_edge_sync
// Purpose  : Two-flop synchroniser plus delay flop; one pulse per rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module ro_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic delay_q, delay_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        delay_d = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            delay_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            delay_q <= delay_d;
        end
    end

    assign rise = sync2_q & ~delay_q;

endmodule
`default_nettype wire

// File: rtl/ro_puf_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ro_puf_counter_ctrl
// Purpose  : Counts edges of two ring oscillators over a fixed window and
//            registers the comparison as the PUF response bit.
// Revision : 1.0 - initial release
// ============================================================================
module ro_puf_counter_ctrl
    import ro_puf_counter_ctrl_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WINDOW = DEF_WINDOW,
    parameter int WIN_W  = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             roen,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic [1:0]       counter_ctrl_state,
    output logic             response_bit,
    output logic             tie,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam logic [WIN_W-1:0] c_LAST_TICK = WIN_W'(WINDOW - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_a_q, count_a_d;
    logic [CNT_W-1:0]   count_b_q, count_b_d;
    logic [WIN_W-1:0]   timer_q, timer_d;
    logic               resp_q, resp_d;
    logic               tie_q, tie_d;

    logic               w_rise_a;
    logic               w_rise_b;
    logic [CNT_W-1:0]   w_count_a_inc;
    logic [CNT_W-1:0]   w_count_b_inc;

    ro_edge_sync u_sync_a (
        .clk      (clk),
        .rst      (rst),
        .async_in (ro_a),
        .rise     (w_rise_a)
    );

    ro_edge_sync u_sync_b (
        .clk      (clk),
        .rst      (rst),
        .async_in (ro_b),
        .rise     (w_rise_b)
    );

    // Saturating increments; the final-cycle compare uses these so the last
    // counted edge is included in the response.
    always_comb begin
        w_count_a_inc = count_a_q;
        w_count_b_inc = count_b_q;
        if (w_rise_a && (count_a_q != '1)) w_count_a_inc = count_a_q + CNT_W'(1);
        if (w_rise_b && (count_b_q != '1)) w_count_b_inc = count_b_q + CNT_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        count_a_d = count_a_q;
        count_b_d = count_b_q;
        timer_d   = timer_q;
        resp_d    = resp_q;
        tie_d     = tie_q;
        case (state_q)
            ST_IDLE: begin
                if (roen) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                count_a_d = '0;
                count_b_d = '0;
                timer_d   = '0;
                state_d   = roen ? ST_COUNT : ST_IDLE;
            end
            ST_COUNT: begin
                if (!roen) begin
                    state_d = ST_IDLE;
                end else begin
                    count_a_d = w_count_a_inc;
                    count_b_d = w_count_b_inc;
                    timer_d   = timer_q + WIN_W'(1);
                    if (timer_q == c_LAST_TICK) begin
                        state_d = ST_DONE;
                        resp_d  = (w_count_a_inc > w_count_b_inc);
                        tie_d   = (w_count_a_inc == w_count_b_inc);
                    end
                end
            end
            ST_DONE: begin
                if (!roen) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_a_q <= '0;
            count_b_q <= '0;
            timer_q   <= '0;
            resp_q    <= 1'b0;
            tie_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_a_q <= count_a_d;
            count_b_q <= count_b_d;
            timer_q   <= timer_d;
            resp_q    <= resp_d;
            tie_q     <= tie_d;
        end
    end

    assign counter_ctrl_state = state_q;
    assign response_bit       = resp_q;
    assign tie                = tie_q;
    assign count_a            = count_a_q;
    assign count_b            = count_b_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ro_puf_counter_ctrl
// Purpose  : Directed self-checking bench for ro_puf_counter_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ro_puf_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst, roen, roen2, ro_a, ro_b;

    logic [1:0] state1, state2;
    logic       resp1, tie1, resp2, tie2;
    logic [7:0] ca1, cb1;
    logic [3:0] ca2, cb2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ro_puf_counter_ctrl #(.CNT_W(8), .WINDOW(64), .WIN_W(7)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .roen               (roen),
        .ro_a               (ro_a),
        .ro_b               (ro_b),
        .counter_ctrl_state (state1),
        .response_bit       (resp1),
        .tie                (tie1),
        .count_a            (ca1),
        .count_b            (cb1)
    );

    // Narrow-counter instance for the saturation case; shares the oscillators.
    ro_puf_counter_ctrl #(.CNT_W(4), .WINDOW(64), .WIN_W(7)) u_dut_sat (
        .clk                (clk),
        .rst                (rst),
        .roen               (roen2),
        .ro_a               (ro_a),
        .ro_b               (ro_b),
        .counter_ctrl_state (state2),
        .response_bit       (resp2),
        .tie                (tie2),
        .count_a            (ca2),
        .count_b            (cb2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // na/nb pulses of period pa/pb (50% duty), then both oscillators low.
    task automatic run_osc(input int pa, input int pb, input int na, input int nb, input int cycles);
        for (int t = 0; t < cycles; t++) begin
            ro_a = (t < na * pa) && ((t % pa) < (pa / 2));
            ro_b = (t < nb * pb) && ((t % pb) < (pb / 2));
            tick();
        end
        ro_a = 1'b0;
        ro_b = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit sat);
        for (int i = 0; i < 100; i++) begin
            if ((sat ? state2 : state1) == 2'b11) break;
            tick();
        end
        check(tag, sat ? state2 : state1, 2'b11);
    endtask

    // DONE -> one low roen cycle -> IDLE -> CLEAR -> COUNT with counts cleared.
    task automatic handshake(input string tag);
        roen = 1'b0;
        tick();
        check({tag, "_idle"}, state1, 2'b00);
        roen = 1'b1;
        tick();
        check({tag, "_clear"}, state1, 2'b01);
        tick();
        check({tag, "_count"}, state1, 2'b10);
        check({tag, "_ca0"}, ca1, 0);
        check({tag, "_cb0"}, cb1, 0);
    endtask

    initial begin
        rst   = 1'b1;
        roen  = 1'b1;
        roen2 = 1'b0;
        ro_a  = 1'b0;
        ro_b  = 1'b0;
        tick();
        tick();
        check("rst_state", state1, 2'b00);
        check("rst_ca", ca1, 0);
        check("rst_cb", cb1, 0);
        check("rst_resp", resp1, 0);
        check("rst_tie", tie1, 0);
        check("rst_state_sat", state2, 2'b00);

        rst = 1'b0;
        tick();
        check("clear_after_rst", state1, 2'b01);

        // Free-running A at period 4, B at period 8 over the whole window.
        run_osc(4, 8, 100, 100, 64);
        check("window_still_count", state1, 2'b10);
        tick();
        check("window_done", state1, 2'b11);
        check("free_ca_range", (ca1 >= 15 && ca1 <= 17), 1);
        check("free_cb_range", (cb1 >= 7 && cb1 <= 9), 1);
        check("free_resp", resp1, 1);
        check("free_tie", tie1, 0);
        tick();
        check("done_hold", state1, 2'b11);
        check("done_resp_hold", resp1, 1);

        // B faster: 5 pulses on A, 10 on B.
        handshake("hs1");
        check("hs1_resp_stable", resp1, 1);
        run_osc(8, 4, 5, 10, 40);
        wait_done("b_fast_done", 1'b0);
        check("b_fast_ca", ca1, 5);
        check("b_fast_cb", cb1, 10);
        check("b_fast_resp", resp1, 0);
        check("b_fast_tie", tie1, 0);

        // Identical oscillators, period 6.
        handshake("hs2");
        run_osc(6, 6, 7, 7, 42);
        wait_done("tie_done", 1'b0);
        check("tie_ca", ca1, 7);
        check("tie_cb", cb1, 7);
        check("tie_resp", resp1, 0);
        check("tie_tie", tie1, 1);

        // A faster, exact burst.
        handshake("hs3");
        run_osc(4, 8, 10, 5, 40);
        wait_done("a_fast_done", 1'b0);
        check("a_fast_ca", ca1, 10);
        check("a_fast_cb", cb1, 5);
        check("a_fast_resp", resp1, 1);
        check("a_fast_tie", tie1, 0);

        // Abort after 20 COUNT cycles with B ahead; response must not update.
        handshake("hs4");
        run_osc(4, 4, 0, 3, 20);
        roen = 1'b0;
        tick();
        check("abort_idle", state1, 2'b00);
        check("abort_ca", ca1, 0);
        check("abort_cb", cb1, 3);
        check("abort_resp_kept", resp1, 1);
        check("abort_tie_kept", tie1, 0);
        tick();
        tick();
        check("abort_stay_idle", state1, 2'b00);
        check("abort_cb_frozen", cb1, 3);
        roen = 1'b1;
        tick();
        check("abort_reclear", state1, 2'b01);
        tick();
        check("abort_recount", state1, 2'b10);
        check("abort_cb_cleared", cb1, 0);
        roen = 1'b0;
        tick();
        check("abort2_idle", state1, 2'b00);

        // Saturation on the 4-bit instance: 30 edges must stop at 15.
        roen2 = 1'b1;
        tick();
        check("sat_clear", state2, 2'b01);
        tick();
        check("sat_count", state2, 2'b10);
        run_osc(2, 2, 30, 0, 60);
        wait_done("sat_done", 1'b1);
        check("sat_ca", ca2, 15);
        check("sat_cb", cb2, 0);
        check("sat_resp", resp2, 1);
        check("sat_tie", tie2, 0);
        roen2 = 1'b0;
        tick();
        check("sat_idle", state2, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ro_puf_counter_ctrl.md
Name: ro_puf_counter_ctrl

Overview:
- Measurement stage directly upstream of the RO PUF controller.
- While the controller asserts roen, this block counts rising edges of two ring-oscillator outputs over a fixed window of clk cycles and compares the two counts.
- It then reports completion on counter_ctrl_state = 2'b11 and presents the response bit that the downstream shift register captures.
- Single clk domain; the oscillator inputs are asynchronous and are synchronised inside the block.

Parameters:
- CNT_W, 16: width of each RO edge counter; counters saturate at all-ones.
- WINDOW, 1024: measurement window length in clk cycles; must be at least 2.
- WIN_W, 11: width of the window timer; must hold WINDOW.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- roen  input  1  ring-oscillator enable from the PUF controller; high requests a measurement.
- ro_a  input  1  asynchronous output of oscillator A.
- ro_b  input  1  asynchronous output of oscillator B.
- counter_ctrl_state  output  2  current state encoding: 00 IDLE, 01 CLEAR, 10 COUNT, 11 DONE.
- response_bit  output  1  comparison result: 1 iff count_a > count_b.
- tie  output  1  1 iff count_a == count_b at the last completed comparison.
- count_a  output  CNT_W  edge count for oscillator A.
- count_b  output  CNT_W  edge count for oscillator B.

Behaviour:
- All outputs are registered. counter_ctrl_state is the state register itself.
- Reset (rst high at a clk edge):
  - state = IDLE; count_a, count_b, window timer, response_bit and tie = 0.
  - Synchroniser and edge-detect flops = 0.
- Synchronisation, per oscillator:
  - 2-flop synchroniser followed by a delay flop.
  - edge = sync_q & ~delay_q, giving one pulse per rising edge.
  - Counting latency is 3 clk from the input edge.
  - Oscillator edges spaced fewer than 2 clk apart are undercounted; this is accepted and not flagged.
- FSM:
  - IDLE: when roen is 1, go to CLEAR; otherwise stay.
  - CLEAR (1 cycle): zero count_a, count_b and the timer. If roen is 1, go to COUNT; else go to IDLE.
  - COUNT:
    - Each cycle, increment count_a on edge_a and count_b on edge_b, saturating at 2^CNT_W-1.
    - The timer increments every cycle. Sampling lasts exactly WINDOW cycles.
    - When timer == WINDOW-1, go to DONE and latch response_bit = (final count_a > final count_b) and tie = (final count_a == final count_b). Final counts include any edge counted in that last cycle.
    - If roen goes to 0 during COUNT, abort to IDLE. Counts freeze; response_bit and tie keep their previous values.
  - DONE:
    - Hold counts, response_bit and tie.
    - Stay in DONE while roen is 1; go to IDLE when roen is 0.
- Handshake with the controller:
  - The controller samples 2'b11, then deasserts roen for exactly one cycle, one cycle later.
  - The block must reach IDLE on that low cycle and re-enter CLEAR on the next roen high, with no lost cycle.
  - response_bit must stay stable from DONE entry until the next DONE entry, so that the one-cycle shift_reg_en pulse samples a valid value.
- Simultaneous events: edge_a and edge_b in the same cycle both count. rst has priority over everything.
- Illegal states: none are reachable with 2-bit encoding; the default branch goes to IDLE.

Decomposition:
- Shared package: state constants ST_IDLE/ST_CLEAR/ST_COUNT/ST_DONE, with ST_DONE = 2'b11 shared with the controller's completion test.
- Package also holds the default CNT_W and WINDOW.
- One sub-module: ro_edge_sync (2-flop synchroniser + rising-edge detector), instantiated twice.

Test Plan (WINDOW=64, CNT_W=8 unless noted):
- Reset: rst high 2 cycles with roen=1 → state 00, counts 0, response_bit 0, tie 0; CLEAR is reached one cycle after rst falls.
- A faster: ro_a period 4 clk, ro_b period 8 clk, roen held → DONE after 1+64 cycles; count_a = 16±1, count_b = 8±1, response_bit 1, tie 0.
- Tie: ro_a and ro_b identical, period 6 clk → count_a == count_b, response_bit 0, tie 1.
- Saturation (CNT_W=4): ro_a period 2 clk → count_a = 15 at DONE, no wrap; response_bit 1 vs ro_b idle.
- Abort: roen drops at COUNT cycle 20 → IDLE next cycle, counts frozen, response_bit keeps its prior value; next roen → CLEAR zeroes counts.
- Closed loop with the PUF controller: 128 bits → every shift_reg_en pulse coincides with a stable response_bit. One-cycle roen low → DONE→IDLE→CLEAR sequence with no stall.
